hist_bank_ctrl: RTL and testbench

Ping-pong bank controller for the tone-curve histogram memories. It owns the bank select that steers `hist_stat` updates into the active bank, and it grants `curve_calc` read access to the inactive bank. After readout it zeroes that bank so it is ready for the next swap. It sits in the top level between `hist_stat`, `curve_calc` and the two {regfile low byte, SRAM high byte} bank pairs.

---
 rtl/hist_pkg.sv | 10 +
 rtl/hist_clr_sweep.sv | 50 +++++
 rtl/hist_bank_ctrl.sv | 119 +++++++++++
 tb/tb_hist_bank_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// hist_pkg: shared types and sizes for the histogram bank controller
// Holds the controller state enum, the bin address/count widths and the
// histogram geometry (levels per block, block count).
package hist_pkg;
    localparam int HIST_ADDR_W  = 11;
    localparam int HIST_CNT_W   = 16;
    localparam int HIST_BINS    = 128;
    localparam int HIST_BLK_MAX = 16;
    typedef enum logic [1:0] {ST_INIT, ST_READY, ST_READ, ST_CLEAR} hist_state_e;
endpackage

// File: rtl/hist_clr_sweep.sv
// hist_clr_sweep: zero-fill address sweep with a registered write port
// Ports:
//   pclk, rst_n        clock, async active-low reset (reset starts a sweep)
//   start              begin a sweep; clr_addr 0 is issued in the start cycle
//   init_mode          tag the writes of this cycle as both-bank writes
//   poke, poke_addr    single zero write when no sweep is running
//   last               write port currently shows address DEPTH-1
//   wr_cen, wr_all     registered write-port enable (active-low) and both-bank tag
//   wr_addr            registered write-port address
module hist_clr_sweep
    import hist_pkg::*;
#(
    parameter int ADDR_W = HIST_ADDR_W
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              init_mode,
    input  logic              poke,
    input  logic [ADDR_W-1:0] poke_addr,
    output logic              last,
    output logic              wr_cen,
    output logic              wr_all,
    output logic [ADDR_W-1:0] wr_addr
);
    logic              busy;
    logic [ADDR_W-1:0] clr_addr;
    logic              issue;
    logic              at_end;
    assign issue  = busy | start;
    assign at_end = &clr_addr;
    // clr_addr wraps to 0 together with the final write, so every sweep starts at 0
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b1;
            clr_addr <= '0;
            last     <= 1'b0;
            wr_cen   <= 1'b1;
            wr_all   <= 1'b0;
            wr_addr  <= '0;
        end else begin
            busy     <= issue & ~at_end;
            clr_addr <= issue ? clr_addr + 1'b1 : clr_addr;
            last     <= issue & at_end;
            wr_cen   <= ~(issue | poke);
            wr_all   <= issue & init_mode;
            wr_addr  <= issue ? clr_addr : poke ? poke_addr : wr_addr;
        end
    end
endmodule

// File: rtl/hist_bank_ctrl.sv
// hist_bank_ctrl: ping-pong bank select, readout grant and zero-clear for histogram memories
// Ports:
//   pclk, rst_n                 pixel clock, async active-low reset
//   swap_req_i / swap_drop_o    bank swap request / rejected-request pulse
//   bank_sel_o, hist_en_o       active statistics bank, statistics update enable
//   rd_req_i, rd_addr_i         curve_calc read request and address
//   rd_done_i                   curve_calc finished with the inactive bank
//   rd_gnt_o, rd_valid_o, rd_data_o   grant, 1-cycle-later valid and data
//   ro_ready_o, clr_busy_o      inactive bank readable / clear sweep running
//   mem_rd_*                    inactive-bank read port (1-cycle latency)
//   mem_wr_*, mem_wdata_o       inactive-bank write port (always writes 0)
//   mem_wr_all_o                write applies to both banks (reset-time sweep)
// Build option HIST_BANK_CTRL_CLEAR_ON_READ_EN: every granted read zeroes its
// bin on the following cycle and the post-readout clear sweep is omitted.
module hist_bank_ctrl
    import hist_pkg::*;
#(
    parameter int ADDR_W = HIST_ADDR_W,
    parameter int CNT_W  = HIST_CNT_W
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              swap_req_i,
    output logic              bank_sel_o,
    output logic              hist_en_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rd_done_i,
    output logic              rd_gnt_o,
    output logic              rd_valid_o,
    output logic [CNT_W-1:0]  rd_data_o,
    output logic              ro_ready_o,
    output logic              mem_rd_cen_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [CNT_W-1:0]  mem_rdata_i,
    output logic              mem_wr_cen_o,
    output logic              mem_wr_wen_o,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [CNT_W-1:0]  mem_wdata_o,
    output logic              mem_wr_all_o,
    output logic              clr_busy_o,
    output logic              swap_drop_o
);
    hist_state_e state;
    logic        sweep_start;
    logic        sweep_last;
    logic        poke;
    assign rd_gnt_o      = (state == ST_READ) & rd_req_i;
    assign mem_rd_cen_o  = ~rd_gnt_o;
    assign mem_rd_addr_o = rd_addr_i;
    assign rd_data_o     = rd_valid_o ? mem_rdata_i : '0;
    assign mem_wr_wen_o  = mem_wr_cen_o;
    assign mem_wdata_o   = '0;
`ifdef HIST_BANK_CTRL_CLEAR_ON_READ_EN
    assign sweep_start = 1'b0;
    assign poke        = rd_gnt_o;
`else
    assign sweep_start = (state == ST_READ) & rd_done_i;
    assign poke        = 1'b0;
`endif
    hist_clr_sweep #(.ADDR_W(ADDR_W)) u_sweep (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .start     (sweep_start),
        .init_mode (state == ST_INIT),
        .poke      (poke),
        .poke_addr (rd_addr_i),
        .last      (sweep_last),
        .wr_cen    (mem_wr_cen_o),
        .wr_all    (mem_wr_all_o),
        .wr_addr   (mem_wr_addr_o)
    );
    // sweeps leave INIT/CLEAR only once the final write is on the port
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            bank_sel_o  <= 1'b0;
            hist_en_o   <= 1'b0;
            ro_ready_o  <= 1'b0;
            clr_busy_o  <= 1'b1;
            rd_valid_o  <= 1'b0;
            swap_drop_o <= 1'b0;
        end else begin
            rd_valid_o  <= rd_gnt_o;
            swap_drop_o <= swap_req_i & (state != ST_READY);
            unique case (state)
                ST_INIT: if (sweep_last) begin
                    state      <= ST_READY;
                    hist_en_o  <= 1'b1;
                    clr_busy_o <= 1'b0;
                end
                ST_READY: if (swap_req_i) begin
                    state      <= ST_READ;
                    bank_sel_o <= ~bank_sel_o;
                    hist_en_o  <= 1'b0;
                    ro_ready_o <= 1'b1;
                end
                ST_READ: if (rd_done_i) begin
                    ro_ready_o <= 1'b0;
`ifdef HIST_BANK_CTRL_CLEAR_ON_READ_EN
                    state      <= ST_READY;
                    hist_en_o  <= 1'b1;
`else
                    state      <= ST_CLEAR;
                    clr_busy_o <= 1'b1;
`endif
                end
`ifndef HIST_BANK_CTRL_CLEAR_ON_READ_EN
                ST_CLEAR: if (sweep_last) begin
                    state      <= ST_READY;
                    hist_en_o  <= 1'b1;
                    clr_busy_o <= 1'b0;
                end
`endif
                default: state <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_hist_bank_ctrl.sv
// tb_hist_bank_ctrl: table, directed and random checks of hist_bank_ctrl against a timeline model
module tb_hist_bank_ctrl;
    localparam int DEPTH = 2048;
`ifdef HIST_BANK_CTRL_CLEAR_ON_READ_EN
    localparam bit COR = 1'b1;
`else
    localparam bit COR = 1'b0;
`endif
    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        swap_req_i, rd_req_i, rd_done_i;
    logic [10:0] rd_addr_i;
    logic        bank_sel_o, hist_en_o, rd_gnt_o, rd_valid_o, ro_ready_o;
    logic [15:0] rd_data_o, mem_rdata_i, mem_wdata_o;
    logic        mem_rd_cen_o, mem_wr_cen_o, mem_wr_wen_o, mem_wr_all_o, clr_busy_o, swap_drop_o;
    logic [10:0] mem_rd_addr_o, mem_wr_addr_o;
    logic [15:0] mem [DEPTH];
    int total = 0, bad = 0;
    always #5 pclk = ~pclk;
    hist_bank_ctrl dut (
        .pclk(pclk), .rst_n(rst_n), .swap_req_i(swap_req_i), .bank_sel_o(bank_sel_o),
        .hist_en_o(hist_en_o), .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_done_i(rd_done_i),
        .rd_gnt_o(rd_gnt_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .ro_ready_o(ro_ready_o),
        .mem_rd_cen_o(mem_rd_cen_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rdata_i(mem_rdata_i),
        .mem_wr_cen_o(mem_wr_cen_o), .mem_wr_wen_o(mem_wr_wen_o), .mem_wr_addr_o(mem_wr_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wr_all_o(mem_wr_all_o), .clr_busy_o(clr_busy_o),
        .swap_drop_o(swap_drop_o)
    );
    // inactive-bank read port with one cycle of latency
    always @(posedge pclk) if (!mem_rd_cen_o) mem_rdata_i <= mem[mem_rd_addr_o];
    // timeline model: a sweep whose address 0 is issued in cycle sw0 writes in
    // cycles sw0+1..sw0+DEPTH; statistics resume once that window has passed
    int          cyc, sw0;
    bit          m_init, m_read, m_bank, m_drop, m_valid, m_poke;
    logic [10:0] m_raddr, m_paddr;
    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, act, exp);
        end
    endfunction
    function automatic bit m_ready();
        return !m_read && cyc > sw0 + DEPTH;
    endfunction
    task automatic m_reset();
        cyc = 0; sw0 = 0; m_init = 1; m_read = 0; m_bank = 0;
        m_drop = 0; m_valid = 0; m_poke = 0; m_raddr = '0; m_paddr = '0;
    endtask
    task automatic apply(bit swap, bit req, logic [10:0] addr, bit done);
        swap_req_i = swap; rd_req_i = req; rd_addr_i = addr; rd_done_i = done;
    endtask
    task automatic sample();
        bit gnt, in_sw, wr;
        @(negedge pclk);
        gnt   = m_read && rd_req_i;
        in_sw = cyc > sw0 && cyc <= sw0 + DEPTH;
        wr    = in_sw || m_poke;
        chk("bank_sel", bank_sel_o, m_bank);
        chk("hist_en", hist_en_o, m_ready());
        chk("ro_ready", ro_ready_o, m_read);
        chk("clr_busy", clr_busy_o, !m_read && cyc <= sw0 + DEPTH);
        chk("rd_gnt", rd_gnt_o, gnt);
        chk("mem_rd_cen", mem_rd_cen_o, !gnt);
        if (gnt) chk("mem_rd_addr", mem_rd_addr_o, rd_addr_i);
        chk("rd_valid", rd_valid_o, m_valid);
        chk("rd_data", rd_data_o, m_valid ? {16'h0, mem[m_raddr]} : 32'h0);
        chk("swap_drop", swap_drop_o, m_drop);
        chk("wr_cen", mem_wr_cen_o, !wr);
        chk("wr_wen", mem_wr_wen_o, !wr);
        if (wr) chk("wr_addr", mem_wr_addr_o, in_sw ? cyc - sw0 - 1 : m_paddr);
        chk("wr_all", mem_wr_all_o, in_sw && m_init);
        chk("wdata", mem_wdata_o, 0);
    endtask
    task automatic advance();
        bit gnt;
        gnt     = m_read && rd_req_i;
        m_drop  = swap_req_i && !m_ready();
        m_valid = gnt;
        m_raddr = rd_addr_i;
        m_poke  = COR && gnt;
        m_paddr = rd_addr_i;
        if (m_ready() && swap_req_i) begin
            m_bank = !m_bank;
            m_read = 1;
        end else if (m_read && rd_done_i) begin
            m_read = 0;
            if (!COR) begin sw0 = cyc; m_init = 0; end
        end
        @(posedge pclk);
        cyc++;
        #1;
    endtask
    task automatic step(bit swap, bit req, logic [10:0] addr, bit done);
        apply(swap, req, addr, done);
        sample();
        advance();
    endtask
    task automatic settle();
        bit r = 0;
        for (int i = 0; i < 2 * DEPTH + 20 && !r; i++) begin
            apply(0, 0, 0, 1);
            sample();
            r = hist_en_o;
            advance();
        end
        chk("settle_timeout", r, 1);
    endtask
    task automatic check_reset();
        chk("rst_bank_sel", bank_sel_o, 0);
        chk("rst_hist_en", hist_en_o, 0);
        chk("rst_ro_ready", ro_ready_o, 0);
        chk("rst_clr_busy", clr_busy_o, 1);
        chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_rd_data", rd_data_o, 0);
        chk("rst_swap_drop", swap_drop_o, 0);
        chk("rst_wr_all", mem_wr_all_o, 0);
        chk("rst_wr_cen", mem_wr_cen_o, 1);
        chk("rst_wr_wen", mem_wr_wen_o, 1);
        chk("rst_wr_addr", mem_wr_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_rd_cen", mem_rd_cen_o, 1);
        chk("rst_rd_gnt", rd_gnt_o, 0);
    endtask
    typedef struct {
        bit swap, req, done;
        logic [10:0] addr;
        bit bank, ro, gnt, valid;
        logic [15:0] data;
        bit drop, wr;
        logic [10:0] waddr;
    } row_t;
    row_t tbl [7];
    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end
    initial begin
        int cnt;
        bit r;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
        mem[5] = 16'h0102; mem[6] = 16'h0304; mem[9] = 16'h0a0b;
        tbl[0] = '{1, 0, 0, 11'd0, 0, 0, 0, 0, 16'h0000, 0, 0, 11'd0};
        tbl[1] = '{0, 1, 0, 11'd5, 1, 1, 1, 0, 16'h0000, 0, 0, 11'd0};
        tbl[2] = '{0, 1, 0, 11'd6, 1, 1, 1, 1, 16'h0102, 0, COR, 11'd5};
        tbl[3] = '{0, 1, 0, 11'd9, 1, 1, 1, 1, 16'h0304, 0, COR, 11'd6};
        tbl[4] = '{1, 0, 0, 11'd0, 1, 1, 0, 1, 16'h0a0b, 0, COR, 11'd9};
        tbl[5] = '{0, 0, 0, 11'd0, 1, 1, 0, 0, 16'h0000, 1, 0, 11'd0};
        tbl[6] = '{1, 0, 1, 11'd0, 1, 1, 0, 0, 16'h0000, 0, 0, 11'd0};
        m_reset();
        apply(0, 1, 11'd3, 0);
        repeat (2) @(posedge pclk);
        #1 check_reset();
        rst_n = 1'b1;
        m_reset();
        for (int i = 0; i <= DEPTH; i++) step(0, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            apply(tbl[k].swap, tbl[k].req, tbl[k].addr, tbl[k].done);
            sample();
            chk($sformatf("tbl%0d_bank", k), bank_sel_o, tbl[k].bank);
            chk($sformatf("tbl%0d_ro", k), ro_ready_o, tbl[k].ro);
            chk($sformatf("tbl%0d_gnt", k), rd_gnt_o, tbl[k].gnt);
            chk($sformatf("tbl%0d_valid", k), rd_valid_o, tbl[k].valid);
            chk($sformatf("tbl%0d_data", k), rd_data_o, tbl[k].data);
            chk($sformatf("tbl%0d_drop", k), swap_drop_o, tbl[k].drop);
            chk($sformatf("tbl%0d_wr", k), !mem_wr_cen_o, tbl[k].wr);
            if (tbl[k].wr) chk($sformatf("tbl%0d_waddr", k), mem_wr_addr_o, tbl[k].waddr);
            advance();
        end
        cnt = 0;
        r = 0;
        for (int i = 0; i < DEPTH + 10 && !r; i++) begin
            apply(i == 100, 0, 0, 0);
            sample();
            if (clr_busy_o) cnt++;
            r = hist_en_o;
            advance();
        end
        chk("clear_done", r, 1);
        chk("clear_len", cnt, COR ? 0 : DEPTH);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        apply(0, 0, 0, 0);
        sample();
        chk("second_swap_bank", bank_sel_o, 0);
        advance();
        for (int i = 0; i < 8000; i++)
            step($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                 11'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 63) == 0);
        settle();
        step(1, 0, 0, 0);
`ifdef HIST_BANK_CTRL_CLEAR_ON_READ_EN
        step(0, 1, 11'd40, 0);
        apply(0, 0, 0, 0);
        sample();
        chk("pre_reset_ro", ro_ready_o, 1);
`else
        step(0, 0, 0, 1);
        r = 0;
        for (int i = 0; i < DEPTH + 10; i++) begin
            apply(0, 0, 0, 0);
            sample();
            if (!mem_wr_cen_o && mem_wr_addr_o == 11'd700) begin r = 1; break; end
            advance();
        end
        chk("reach_addr_700", r, 1);
`endif
        apply(0, 1, 11'd7, 0);
        rst_n = 1'b0;
        #1 check_reset();
        repeat (2) @(posedge pclk);
        #1 rst_n = 1'b1;
        m_reset();
        for (int i = 0; i <= DEPTH; i++) step(0, 0, 0, 0);
        apply(0, 0, 0, 0);
        sample();
        chk("reinit_ready", hist_en_o, 1);
        chk("reinit_bank", bank_sel_o, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
